// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the cache line write-back/fill controller.
// Holds the transfer state encoding, default geometry and line alignment.
package mem_ctrl_pkg;

  localparam int unsigned DEF_LINE_BYTES = 4;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned MAX_ADDR_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clears the byte-offset bits so any address inside a line maps to its base.
  function automatic logic [MAX_ADDR_W-1:0] line_base(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           offset_w
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = ~((MAX_ADDR_W'(1) << offset_w) - MAX_ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_beat_sequencer.sv
// Beat counter plus per-beat wait timer shared by the write-back and fill phases.
// A beat lasts 1+WAIT_CYCLES enabled cycles; the beat index wraps at the line end.
module mem_beat_sequencer #(
  parameter  int unsigned LINE_BYTES  = 4,
  parameter  int unsigned WAIT_CYCLES = 0,
  localparam int unsigned IDX_W       = $clog2(LINE_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  output logic [IDX_W-1:0] beat_idx,
  output logic             beat_last_cycle,
  output logic             line_last_beat
);

  assign line_last_beat = (beat_idx == IDX_W'(LINE_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
    end else if (start) begin
      beat_idx <= '0;
    end else if (enable && beat_last_cycle) begin
      beat_idx <= beat_idx + IDX_W'(1);
    end
  end

  if (WAIT_CYCLES == 0) begin : g_no_wait
    assign beat_last_cycle = 1'b1;
  end else begin : g_wait
    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_cnt <= '0;
      end else if (start) begin
        wait_cnt <= '0;
      end else if (enable) begin
        if (beat_last_cycle) wait_cnt <= '0;
        else                 wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end

    assign beat_last_cycle = (wait_cnt == WAIT_W'(WAIT_CYCLES));
  end

endmodule

// File: rtl/mem_line_fill_ctrl.sv
// Cache-side initiator of the byte-wide memory port: optional dirty-line
// write-back followed by a byte-by-byte fill of the missing line.
module mem_line_fill_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_BYTES  = DEF_LINE_BYTES,
  parameter  int unsigned ADDR_W      = DEF_ADDR_W,
  parameter  int unsigned WAIT_CYCLES = 0,
  localparam int unsigned IDX_W       = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write_back,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic [IDX_W-1:0]  wb_byte_idx,
  input  logic [7:0]        wb_byte_data,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_byte_idx,
  output logic [7:0]        fill_byte_data,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_is_write,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] wb_base;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] req_wb_base;
  logic [ADDR_W-1:0] req_fill_base;
  logic              accept;
  logic              seq_enable;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  next_idx;
  logic              beat_last_cycle;
  logic              line_last_beat;

  assign req_wb_base   = ADDR_W'(line_base(MAX_ADDR_W'(req_wb_addr), IDX_W));
  assign req_fill_base = ADDR_W'(line_base(MAX_ADDR_W'(req_fill_addr), IDX_W));

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign seq_enable = (state == WB) || (state == FILL);
  assign next_idx   = beat_idx + IDX_W'(1);

  mem_beat_sequencer #(
    .LINE_BYTES  (LINE_BYTES),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_seq (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (accept),
    .enable          (seq_enable),
    .beat_idx        (beat_idx),
    .beat_last_cycle (beat_last_cycle),
    .line_last_beat  (line_last_beat)
  );

  // The cache array answers combinationally, so the victim byte index follows
  // the beat counter and its data is forwarded straight onto the bus.
  assign wb_byte_idx = beat_idx;

  // NOTE: a continuous assign with a full ternary covers every case, so no
  // latch can be inferred for this combinational output.
  assign mem_wdata = (state == WB) ? wb_byte_data : 8'h00;

  // Base low bits are zero, so OR-ing the index never carries into the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      mem_addr       <= '0;
      mem_is_write   <= 1'b0;
      fill_we        <= 1'b0;
      fill_byte_idx  <= '0;
      fill_byte_data <= '0;
      done           <= 1'b0;
      wb_base        <= '0;
      fill_base      <= '0;
    end else begin
      fill_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            wb_base   <= req_wb_base;
            fill_base <= req_fill_base;
            if (req_write_back) begin
              state        <= WB;
              mem_addr     <= req_wb_base;
              mem_is_write <= 1'b1;
            end else begin
              state        <= FILL;
              mem_addr     <= req_fill_base;
              mem_is_write <= 1'b0;
            end
          end
        end
        WB: begin
          if (beat_last_cycle) begin
            if (line_last_beat) begin
              state        <= FILL;
              mem_addr     <= fill_base;
              mem_is_write <= 1'b0;
            end else begin
              mem_addr <= wb_base | ADDR_W'(next_idx);
            end
          end
        end
        FILL: begin
          if (beat_last_cycle) begin
            fill_we        <= 1'b1;
            fill_byte_idx  <= beat_idx;
            fill_byte_data <= mem_rdata;
            if (line_last_beat) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              mem_addr <= fill_base | ADDR_W'(next_idx);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_fill_ctrl.sv
// Directed bench for mem_line_fill_ctrl: fill, write-back+fill, wait states,
// busy rejection, mid-transfer reset and address wrap at the top of memory.
module tb_mem_line_fill_ctrl;

  logic        clk;
  logic        rst_n;

  // Zero-wait instance
  logic        req_valid, req_ready, req_write_back;
  logic [31:0] req_wb_addr, req_fill_addr;
  logic [1:0]  wb_byte_idx, fill_byte_idx;
  logic [7:0]  wb_byte_data, fill_byte_data, mem_wdata, mem_rdata;
  logic        fill_we, done, mem_is_write;
  logic [31:0] mem_addr;

  // Two-wait-cycle instance
  logic        req_valid_w, req_ready_w;
  logic [31:0] req_fill_addr_w;
  logic [1:0]  wb_byte_idx_w, fill_byte_idx_w;
  logic [7:0]  fill_byte_data_w, mem_wdata_w, mem_rdata_w;
  logic        fill_we_w, done_w, mem_is_write_w;
  logic [31:0] mem_addr_w;

  logic [7:0]  cache_line [4];
  logic [7:0]  lbuf [4];
  logic [7:0]  lbuf_w [4];
  logic [39:0] wr_log [$];
  logic [31:0] rd_log [$];
  int          fill_cnt, done_cnt, done_cnt_w;
  int          n_vec, n_miss;

  // Memory returns the low address byte; the cache array is a 4-byte table.
  assign mem_rdata    = mem_addr[7:0];
  assign mem_rdata_w  = mem_addr_w[7:0];
  assign wb_byte_data = cache_line[wb_byte_idx];

  mem_line_fill_ctrl #(.LINE_BYTES(4), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write_back(req_write_back),
    .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
    .wb_byte_idx(wb_byte_idx), .wb_byte_data(wb_byte_data),
    .fill_we(fill_we), .fill_byte_idx(fill_byte_idx), .fill_byte_data(fill_byte_data),
    .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_is_write(mem_is_write), .mem_rdata(mem_rdata)
  );

  mem_line_fill_ctrl #(.LINE_BYTES(4), .ADDR_W(32), .WAIT_CYCLES(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_write_back(1'b0),
    .req_wb_addr(32'h0), .req_fill_addr(req_fill_addr_w),
    .wb_byte_idx(wb_byte_idx_w), .wb_byte_data(8'h00),
    .fill_we(fill_we_w), .fill_byte_idx(fill_byte_idx_w), .fill_byte_data(fill_byte_data_w),
    .done(done_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
    .mem_is_write(mem_is_write_w), .mem_rdata(mem_rdata_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus and line-buffer observers, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_is_write)               wr_log.push_back({mem_addr, mem_wdata});
      else if (!req_ready && !done)   rd_log.push_back(mem_addr);
      if (fill_we) begin
        lbuf[fill_byte_idx] = fill_byte_data;
        fill_cnt++;
      end
      if (done)   done_cnt++;
      if (fill_we_w) lbuf_w[fill_byte_idx_w] = fill_byte_data_w;
      if (done_w) done_cnt_w++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wb, input logic [31:0] wba, input logic [31:0] fa,
                           input logic hold);
    @(negedge clk);
    #1;
    wr_log.delete();
    rd_log.delete();
    fill_cnt = 0;
    for (int i = 0; i < 4; i++) lbuf[i] = 8'hEE;
    req_write_back = wb;
    req_wb_addr    = wba;
    req_fill_addr  = fa;
    req_valid      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until done is seen.
  task automatic run_to_done(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (done === 1'b1) break;
    end
    #1;
  endtask

  task automatic check_fill(input string tag, input logic [31:0] base);
    check({tag, "_rd_cnt"}, 64'(rd_log.size()), 64'd4);
    check({tag, "_we_cnt"}, 64'(fill_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_rd_addr%0d", tag, i),
            (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hDEAD, 64'(base + 32'(i)));
      check($sformatf("%s_buf%0d", tag, i), 64'(lbuf[i]), 64'(base[7:0] + 8'(i)));
    end
  endtask

  initial begin
    int lat;
    int d0;
    n_vec = 0; n_miss = 0; fill_cnt = 0; done_cnt = 0; done_cnt_w = 0;
    cache_line[0] = 8'h11; cache_line[1] = 8'h22;
    cache_line[2] = 8'h33; cache_line[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin lbuf[i] = 8'hEE; lbuf_w[i] = 8'hEE; end
    rst_n = 1'b0;
    req_valid = 1'b0; req_write_back = 1'b0; req_wb_addr = '0; req_fill_addr = '0;
    req_valid_w = 1'b0; req_fill_addr_w = '0;

    // Reset values
    #12;
    check("rst_ready",     64'(req_ready), 64'd1);
    check("rst_addr",      64'(mem_addr), 64'd0);
    check("rst_wdata",     64'(mem_wdata), 64'd0);
    check("rst_is_write",  64'(mem_is_write), 64'd0);
    check("rst_fill_we",   64'(fill_we), 64'd0);
    check("rst_fill_idx",  64'(fill_byte_idx), 64'd0);
    check("rst_fill_data", 64'(fill_byte_data), 64'd0);
    check("rst_wb_idx",    64'(wb_byte_idx), 64'd0);
    check("rst_done",      64'(done), 64'd0);
    check("rst_w_ready",   64'(req_ready_w), 64'd1);
    check("rst_w_wb_idx",  64'(wb_byte_idx_w), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill only, miss address inside line 0x124
    start_req(1'b0, 32'h0, 32'h0000_0126, 1'b0);
    run_to_done(lat);
    check("fill_latency", 64'(lat), 64'd5);
    check("fill_fwe_idx3", 64'(fill_byte_idx), 64'd3);
    check("fill_wr_cnt", 64'(wr_log.size()), 64'd0);
    check_fill("fill", 32'h0000_0124);
    @(negedge clk);
    check("fill_idle_ready", 64'(req_ready), 64'd1);
    check("fill_idle_addr",  64'(mem_addr), 64'h127);
    check("fill_idle_is_wr", 64'(mem_is_write), 64'd0);
    check("fill_idle_done",  64'(done), 64'd0);

    // Dirty victim write-back, then fill of line 0x40
    start_req(1'b1, 32'h0000_0A03, 32'h0000_0040, 1'b0);
    run_to_done(lat);
    check("wb_latency", 64'(lat), 64'd9);
    check("wb_wr_cnt", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wb_beat%0d", i),
            (i < wr_log.size()) ? 64'(wr_log[i]) : 64'hDEAD,
            64'({32'h0000_0A00 + 32'(i), cache_line[i]}));
    end
    check_fill("wbf", 32'h0000_0040);

    // Two wait cycles per beat on the second instance
    @(negedge clk);
    #1;
    req_fill_addr_w = 32'h0000_0080;
    req_valid_w = 1'b1;
    @(posedge clk);
    #1;
    req_valid_w = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("w2_addr_c%0d", n), 64'(mem_addr_w), 64'(32'h80 + 32'((n - 1) / 3)));
      check($sformatf("w2_done_c%0d", n), 64'(done_w), 64'd0);
      if (n == 4) check("w2_fwe_c4", 64'({fill_we_w, fill_byte_idx_w, fill_byte_data_w}),
                        64'({1'b1, 2'd0, 8'h80}));
      if (n == 5) check("w2_fwe_c5", 64'(fill_we_w), 64'd0);
    end
    @(negedge clk);
    check("w2_done_c13", 64'(done_w), 64'd1);
    check("w2_is_write", 64'(mem_is_write_w), 64'd0);
    check("w2_wdata", 64'(mem_wdata_w), 64'd0);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("w2_buf%0d", i), 64'(lbuf_w[i]), 64'(8'h80 + 8'(i)));
    check("w2_done_cnt", 64'(done_cnt_w), 64'd1);

    // Busy rejection: req_valid held high across a whole fill
    d0 = done_cnt;
    start_req(1'b0, 32'h0, 32'h0000_0200, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("busy_ready_c%0d", n), 64'(req_ready), 64'd0);
    end
    check("busy_done_c5", 64'(done), 64'd1);
    @(negedge clk);
    #1;
    check("busy_ready_c6", 64'(req_ready), 64'd1);
    check("busy_one_done", 64'(done_cnt - d0), 64'd1);
    check("busy_one_fill", 64'(fill_cnt), 64'd4);
    @(negedge clk);
    check("busy_reaccept", 64'(req_ready), 64'd0);
    #1;
    req_valid = 1'b0;
    run_to_done(lat);
    check("busy_second_lat", 64'(lat), 64'd4);
    check("busy_two_dones", 64'(done_cnt - d0), 64'd2);
    check("busy_rd_cnt", 64'(rd_log.size()), 64'd8);

    // Reset during beat 2 of a fill
    d0 = done_cnt;
    start_req(1'b0, 32'h0, 32'h0000_0300, 1'b0);
    repeat (3) @(negedge clk);
    check("mrst_beat2_addr", 64'(mem_addr), 64'h302);
    rst_n = 1'b0;
    #1;
    check("mrst_ready", 64'(req_ready), 64'd1);
    check("mrst_addr",  64'(mem_addr), 64'd0);
    check("mrst_fill",  64'({fill_we, fill_byte_idx, fill_byte_data}), 64'd0);
    check("mrst_done",  64'(done), 64'd0);
    check("mrst_wb_idx", 64'(wb_byte_idx), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    start_req(1'b0, 32'h0, 32'h0000_0400, 1'b0);
    run_to_done(lat);
    check("mrst_next_lat", 64'(lat), 64'd5);
    check_fill("mrst", 32'h0000_0400);

    // Top-of-memory line: no carry past the base
    start_req(1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_to_done(lat);
    check("wrap_latency", 64'(lat), 64'd5);
    check_fill("wrap", 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
